// File: rtl/regfile_8x16_byp_pkg.sv
// Shared sizing constants and lane helper for the 8x16 register file.
package regfile_8x16_byp_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;
    localparam int FLAT_W   = REG_W * NUM_REGS;
    localparam int CNT_W    = 8;

    // Lane i of a flattened register image occupies bits [i*REG_W +: REG_W].
    function automatic logic [REG_W-1:0] reg_lane(input logic [FLAT_W-1:0] flat,
                                                  input logic [SEL_W-1:0]  sel);
        return flat[int'(sel)*REG_W +: REG_W];
    endfunction

endpackage

// File: rtl/regfile_8x16_byp_bypass_port.sv
// One read port: selects a register from the flat image and optionally forwards
// the in-flight write data when the indices match.
module regfile_bypass_port
    import regfile_8x16_byp_pkg::*;
#(
    parameter bit BYPASS = 1'b1
) (
    input  logic [FLAT_W-1:0] regs_flat,
    input  logic [SEL_W-1:0]  rd_sel,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [REG_W-1:0]  wr_data,
    input  logic              wr_act,
    output logic [REG_W-1:0]  rd_data
);

    always_comb begin
        rd_data = reg_lane(regs_flat, rd_sel);
        if (BYPASS && wr_act && (rd_sel == wr_sel)) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/regfile_8x16_byp.sv
// 8 x 16-bit register file: two combinational read ports with optional
// write-to-read forwarding, a flat snapshot of all registers, and a write counter.
module regfile_8x16_byp
    import regfile_8x16_byp_pkg::*;
#(
    parameter bit               BYPASS    = 1'b1,
    parameter logic [REG_W-1:0] RESET_VAL = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SEL_W-1:0]  read1RegSel,
    input  logic [SEL_W-1:0]  read2RegSel,
    input  logic [SEL_W-1:0]  writeRegSel,
    input  logic [REG_W-1:0]  writeData,
    input  logic              writeEn,
    output logic [REG_W-1:0]  read1Data,
    output logic [REG_W-1:0]  read2Data,
    output logic [FLAT_W-1:0] regsFlat,
    output logic [CNT_W-1:0]  wrCount
);

    logic [REG_W-1:0] regs [NUM_REGS];
    logic             wr_act;

    // Forwarding is suppressed while reset is held so reads return RESET_VAL.
    assign wr_act = writeEn & rst;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VAL;
            end
            wrCount <= '0;
        end else if (writeEn) begin
            regs[writeRegSel] <= writeData;
            wrCount           <= wrCount + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regsFlat[g*REG_W +: REG_W] = regs[g];
    end

    regfile_bypass_port #(.BYPASS(BYPASS)) u_port1 (
        .regs_flat (regsFlat),
        .rd_sel    (read1RegSel),
        .wr_sel    (writeRegSel),
        .wr_data   (writeData),
        .wr_act    (wr_act),
        .rd_data   (read1Data)
    );

    regfile_bypass_port #(.BYPASS(BYPASS)) u_port2 (
        .regs_flat (regsFlat),
        .rd_sel    (read2RegSel),
        .wr_sel    (writeRegSel),
        .wr_data   (writeData),
        .wr_act    (wr_act),
        .rd_data   (read2Data)
    );

endmodule

// File: tb/tb_regfile_8x16_byp.sv
// Directed bench for regfile_8x16_byp: one forwarding and one non-forwarding
// instance share stimulus so both read behaviours are compared side by side.
module tb_regfile_8x16_byp;

    logic         clk;
    logic         rst;
    logic [2:0]   read1RegSel;
    logic [2:0]   read2RegSel;
    logic [2:0]   writeRegSel;
    logic [15:0]  writeData;
    logic         writeEn;

    logic [15:0]  b_read1Data, b_read2Data, n_read1Data, n_read2Data;
    logic [127:0] b_regsFlat, n_regsFlat;
    logic [7:0]   b_wrCount, n_wrCount;

    int checks;
    int errors;

    typedef struct {
        logic        we;
        logic [2:0]  wsel;
        logic [15:0] wdata;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] n1;
        logic [15:0] n2;
        logic [15:0] r3;
        logic [7:0]  cnt;
    } vec_t;

    vec_t vec [8];

    regfile_8x16_byp #(.BYPASS(1'b1), .RESET_VAL(16'h0000)) dut_byp (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .read1Data   (b_read1Data),
        .read2Data   (b_read2Data),
        .regsFlat    (b_regsFlat),
        .wrCount     (b_wrCount)
    );

    regfile_8x16_byp #(.BYPASS(1'b0), .RESET_VAL(16'h0000)) dut_nb (
        .clk         (clk),
        .rst         (rst),
        .read1RegSel (read1RegSel),
        .read2RegSel (read2RegSel),
        .writeRegSel (writeRegSel),
        .writeData   (writeData),
        .writeEn     (writeEn),
        .read1Data   (n_read1Data),
        .read2Data   (n_read2Data),
        .regsFlat    (n_regsFlat),
        .wrCount     (n_wrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        writeEn     = v.we;
        writeRegSel = v.wsel;
        writeData   = v.wdata;
        read1RegSel = v.r1;
        read2RegSel = v.r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        writeEn = 1'b0;
        writeRegSel = 3'd0;
        writeData = 16'h0;
        read1RegSel = 3'd0;
        read2RegSel = 3'd0;

        // fields: we wsel wdata r1 r2 | byp r1 r2 | nobyp r1 r2 | R3 lane | wrCount before edge
        vec[0] = '{1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 8'd0};
        vec[1] = '{1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 8'd1};
        vec[2] = '{1'b1, 3'd5, 16'h1234, 3'd3, 3'd5, 16'hBEEF, 16'h1234, 16'hBEEF, 16'h0000, 16'hBEEF, 8'd1};
        vec[3] = '{1'b1, 3'd7, 16'hAAAA, 3'd7, 3'd5, 16'hAAAA, 16'h1234, 16'h0000, 16'h1234, 16'hBEEF, 8'd2};
        vec[4] = '{1'b1, 3'd7, 16'h5555, 3'd7, 3'd7, 16'h5555, 16'h5555, 16'hAAAA, 16'hAAAA, 16'hBEEF, 8'd3};
        vec[5] = '{1'b0, 3'd7, 16'hFFFF, 3'd7, 3'd5, 16'h5555, 16'h1234, 16'h5555, 16'h1234, 16'hBEEF, 8'd4};
        vec[6] = '{1'b1, 3'd0, 16'h0001, 3'd0, 3'd3, 16'h0001, 16'hBEEF, 16'h0000, 16'hBEEF, 16'hBEEF, 8'd4};
        vec[7] = '{1'b0, 3'd0, 16'h0000, 3'd0, 3'd6, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'hBEEF, 8'd5};

        // Reset state before any clock edge.
        #2;
        checkOutput("rst_flat_byp", b_regsFlat, 128'h0);
        checkOutput("rst_flat_nb",  n_regsFlat, 128'h0);
        checkOutput("rst_cnt_byp",  {120'h0, b_wrCount}, 128'h0);
        checkOutput("rst_rd1_byp",  {112'h0, b_read1Data}, 128'h0);
        checkOutput("rst_rd2_byp",  {112'h0, b_read2Data}, 128'h0);

        @(posedge clk);
        #3 rst = 1'b1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vec[i]);
            #1;
            checkOutput($sformatf("row%0d_byp_rd1", i), {112'h0, b_read1Data}, {112'h0, vec[i].b1});
            checkOutput($sformatf("row%0d_byp_rd2", i), {112'h0, b_read2Data}, {112'h0, vec[i].b2});
            checkOutput($sformatf("row%0d_nb_rd1", i),  {112'h0, n_read1Data}, {112'h0, vec[i].n1});
            checkOutput($sformatf("row%0d_nb_rd2", i),  {112'h0, n_read2Data}, {112'h0, vec[i].n2});
            checkOutput($sformatf("row%0d_byp_cnt", i), {120'h0, b_wrCount}, {120'h0, vec[i].cnt});
            checkOutput($sformatf("row%0d_nb_cnt", i),  {120'h0, n_wrCount}, {120'h0, vec[i].cnt});
            checkOutput($sformatf("row%0d_byp_r3", i),  {112'h0, b_regsFlat[63:48]}, {112'h0, vec[i].r3});
            checkOutput($sformatf("row%0d_nb_r3", i),   {112'h0, n_regsFlat[63:48]}, {112'h0, vec[i].r3});
            tick();
        end
        checkOutput("table_cnt_byp",  {120'h0, b_wrCount}, {120'h0, 8'd5});
        checkOutput("table_flat_byp", b_regsFlat, 128'h5555_0000_1234_0000_BEEF_0000_0000_0001);
        checkOutput("table_flat_nb",  n_regsFlat, 128'h5555_0000_1234_0000_BEEF_0000_0000_0001);

        // Reset asserted between edges in the middle of a write burst.
        writeEn = 1'b1;
        writeRegSel = 3'd1;
        writeData = 16'hCAFE;
        read1RegSel = 3'd1;
        tick();
        checkOutput("burst_r1_cafe", {112'h0, b_regsFlat[31:16]}, {112'h0, 16'hCAFE});
        writeRegSel = 3'd2;
        writeData = 16'h1111;
        #2 rst = 1'b0;
        #1;
        checkOutput("async_rst_flat_byp", b_regsFlat, 128'h0);
        checkOutput("async_rst_flat_nb",  n_regsFlat, 128'h0);
        checkOutput("async_rst_cnt",      {120'h0, b_wrCount}, 128'h0);
        checkOutput("async_rst_rd1",      {112'h0, b_read1Data}, 128'h0);
        read1RegSel = 3'd2;
        read2RegSel = 3'd2;
        #1;
        checkOutput("rst_bypass_rd1", {112'h0, b_read1Data}, 128'h0);
        checkOutput("rst_bypass_rd2", {112'h0, b_read2Data}, 128'h0);
        tick();
        checkOutput("rst_edge_flat", b_regsFlat, 128'h0);
        checkOutput("rst_edge_cnt",  {120'h0, b_wrCount}, 128'h0);

        // Release between edges with a write pending: the next edge must take it.
        writeRegSel = 3'd1;
        writeData = 16'hD00D;
        #1 rst = 1'b1;
        tick();
        checkOutput("release_flat_byp", b_regsFlat, {96'h0, 16'hD00D, 16'h0000});
        checkOutput("release_flat_nb",  n_regsFlat, {96'h0, 16'hD00D, 16'h0000});
        checkOutput("release_cnt",      {120'h0, b_wrCount}, {120'h0, 8'd1});

        // Counter wrap: 255 writes reach FF, the 256th wraps to 00.
        rst = 1'b0;
        #1 rst = 1'b1;
        writeEn = 1'b1;
        for (int i = 0; i < 255; i++) begin
            writeRegSel = 3'(i);
            writeData = 16'(i);
            tick();
        end
        checkOutput("cnt_255_byp", {120'h0, b_wrCount}, {120'h0, 8'hFF});
        checkOutput("cnt_255_nb",  {120'h0, n_wrCount}, {120'h0, 8'hFF});
        writeRegSel = 3'd7;
        writeData = 16'h00FF;
        tick();
        checkOutput("cnt_256_wrap", {120'h0, b_wrCount}, 128'h0);
        checkOutput("wrap_r7",      {112'h0, b_regsFlat[127:112]}, {112'h0, 16'h00FF});
        writeEn = 1'b0;
        writeData = 16'hABCD;
        tick();
        checkOutput("idle_cnt_hold", {120'h0, b_wrCount}, 128'h0);
        checkOutput("idle_r7_hold",  {112'h0, b_regsFlat[127:112]}, {112'h0, 16'h00FF});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_8x16_byp.md
REGFILE_8X16_BYP -- requirements
Module: regfile_8x16_byp

Interface
REQ-001 Parameter BYPASS, default 1, meaning: 1 = same-cycle write-to-read forwarding on both read ports, 0 = reads return the pre-write value.
REQ-002 Parameter RESET_VAL, default 16'h0000, meaning: value loaded into every register on reset.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 read1RegSel  input  3  register index for read port 1.
REQ-006 read2RegSel  input  3  register index for read port 2.
REQ-007 writeRegSel  input  3  register index for the write port.
REQ-008 writeData  input  16  data to be written.
REQ-009 writeEn  input  1  write strobe, sampled on rising clk.
REQ-010 read1Data  output  16  combinational read port 1.
REQ-011 read2Data  output  16  combinational read port 2.
REQ-012 regsFlat  output  128  registered snapshot of all registers; R0 in [15:0] through R7 in [127:112], 16-bit lanes in ascending index order, for the downstream 8:1 selector.
REQ-013 wrCount  output  8  count of accepted writes, wraps.

Function
REQ-014 Storage: 8 registers x 16 bits; no hard-wired zero register.
REQ-015 Write: writeEn=1 at a rising clk loads writeData into R[writeRegSel]; all other registers hold.
REQ-016 writeEn=0: no register changes; wrCount holds.
REQ-017 Read latency 0: read1Data = R[read1RegSel] and read2Data = R[read2RegSel], combinational.
REQ-018 Bypass (BYPASS=1): when writeEn=1 and readNRegSel==writeRegSel, readNData = writeData in the same cycle; both ports independently.
REQ-019 BYPASS=0: readNData always equals the stored value; the new value is visible from the cycle after the write edge.
REQ-020 Same-index reads: both ports may select the same register and return identical data.
REQ-021 regsFlat: reflects register contents after each rising edge; never bypassed; a write is visible on regsFlat one cycle after writeEn.
REQ-022 wrCount: increments by 1 on each accepted write; 8'hFF + 1 wraps to 8'h00 with no flag.
REQ-023 Back-to-back writes to the same register: the last write wins; each write counts.

Reset
REQ-024 rst low asynchronously forces all registers to RESET_VAL, regsFlat to {8{RESET_VAL}}, and wrCount to 0, independent of clk.
REQ-025 While rst is low, writes are ignored; read ports return RESET_VAL, including a matching bypass case.
REQ-026 Reset deasserted mid-write: a write occurs only on the first rising edge with rst high and writeEn high.

Structure
REQ-027 Shared package: REG_W=16, NUM_REGS=8, SEL_W=3, FLAT_W=128.
REQ-028 One sub-module, regfile_bypass_port, instantiated twice: read-select mux plus the bypass compare.

Verification
REQ-029 Reset: rst low with no clk -> regsFlat=128'h0, wrCount=0, read1Data=read2Data=16'h0.
REQ-030 Write R3=16'hBEEF, next cycle read1RegSel=3 -> read1Data=16'hBEEF; regsFlat[63:48]=16'hBEEF.
REQ-031 BYPASS=1, same cycle: writeEn=1, writeRegSel=5, writeData=16'h1234, read2RegSel=5 -> read2Data=16'h1234 before the edge; with BYPASS=0 it is the old value.
REQ-032 Write R7=16'hAAAA, then R7=16'h5555 back-to-back -> R7=16'h5555, wrCount += 2.
REQ-033 256 consecutive writes from wrCount=0 -> wrCount=8'h00; 255 writes -> 8'hFF.
REQ-034 Assert rst mid-write burst with R1=16'hCAFE -> R1 becomes 16'h0 immediately without a clock edge; the write on the first edge after release lands.
